// File: rtl/alu_io_pkg.sv
// Shared definitions for the board I/O path in front of the ALU:
// button indices, the default operand width and small helpers.
package alu_io_pkg;

  localparam int ALU_N_SWITCH = 6;
  localparam int N_BTN        = 3;

  localparam int BTN_A  = 2;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 0;

  typedef logic [N_BTN-1:0] btn_vec_t;

  // Loaded-flag pattern after an A press restarts a complete operand set
  localparam btn_vec_t LOADED_RESTART = btn_vec_t'(1) << BTN_A;

  function automatic logic [1:0] count_ones(input btn_vec_t v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: 2-flop synchroniser, counter debouncer holding a stable
// level, and a registered one-cycle strobe on each accepted rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             sync;

  assign sync = sync_q[1];

  // press is raised at the same edge that flips stable high, so it is a
  // registered strobe covering the first cycle of the new stable level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      press  <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync;
        cnt    <= '0;
        press  <= sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Operand/opcode capture front-end: debounced button presses load the switch
// bank into A, B or Op, with sticky loaded flags and a registered ready.
module alu_operand_loader
  import alu_io_pkg::*;
#(
  parameter  int N_SWITCH        = ALU_N_SWITCH,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_SWITCH-1:0] switches,
  input  logic [2:0]          buttons,
  output logic [N_SWITCH-1:0] data_a,
  output logic [N_SWITCH-1:0] data_b,
  output logic [N_SWITCH-1:0] op,
  output logic [2:0]          loaded,
  output logic                ready,
  output logic [2:0]          load_pulse,
  output logic                conflict
);

  btn_vec_t   press;
  btn_vec_t   loaded_next;
  logic [1:0] n_press;
  logic       single;

  for (genvar i = 0; i < N_BTN; i++) begin : gen_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debouncer (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (buttons[i]),
      .press  (press[i])
    );
  end

  always_comb begin
    n_press     = count_ones(press);
    single      = (n_press == 2'd1);
    conflict    = (n_press > 2'd1);
    load_pulse  = single ? press : '0;
    loaded_next = loaded;
    if (single) begin
      if (press[BTN_A] && ready) loaded_next = LOADED_RESTART;
      else                       loaded_next = loaded | press;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_a <= '0;
      data_b <= '0;
      op     <= '0;
      loaded <= '0;
      ready  <= 1'b0;
    end else begin
      if (single) begin
        if (press[BTN_A])  data_a <= switches;
        if (press[BTN_B])  data_b <= switches;
        if (press[BTN_OP]) op     <= switches;
      end
      loaded <= loaded_next;
      ready  <= &loaded_next;
    end
  end

endmodule
